// File: rtl/multi_ch_fifo.sv
// multi_ch_fifo: NUM_CH independent circular FIFOs sharing one write port and
// one round-robin arbitrated read port.
//
// Ports:
//   clk_i          single clock, rising edge
//   rst_i          asynchronous active-high reset (pointers, arbiter, lock FSM)
//   flush_i        per-channel synchronous clear
//   src_data_i     write payload
//   src_ch_i       write target channel
//   src_valid_i    write request
//   src_ready_o    write accepted when high with src_valid_i (combinational)
//   dst_data_o     head payload of the granted channel (combinational)
//   dst_ch_o       granted channel index (combinational)
//   dst_valid_o    some channel is eligible for reading (combinational)
//   dst_ready_i    consumer accepts
//   usage_o        per-channel fill level (combinational from pointers)
//   almost_full_o  per-channel usage >= AF_THRESH
module multi_ch_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter type         T         = logic [WIDTH-1:0],
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned LOG_DEPTH = 3,
  parameter int unsigned AF_THRESH = 2**LOG_DEPTH - 1,
  localparam int unsigned ChW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned CntW     = LOG_DEPTH + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CH-1:0]              flush_i,
  input  T                               src_data_i,
  input  logic [ChW-1:0]                 src_ch_i,
  input  logic                           src_valid_i,
  output logic                           src_ready_o,
  output T                               dst_data_o,
  output logic [ChW-1:0]                 dst_ch_o,
  output logic                           dst_valid_o,
  input  logic                           dst_ready_i,
  output logic [NUM_CH-1:0][CntW-1:0]    usage_o,
  output logic [NUM_CH-1:0]              almost_full_o
);

  localparam int unsigned Depth = 2**LOG_DEPTH;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                      state_q, state_d;
  logic [ChW-1:0]              lock_ch_q, lock_ch_d;
  logic [ChW-1:0]              rr_q, rr_d;
  logic [NUM_CH-1:0][CntW-1:0] wptr_q, wptr_d;
  logic [NUM_CH-1:0][CntW-1:0] rptr_q, rptr_d;
  T                            mem_q [NUM_CH][Depth];

  logic [NUM_CH-1:0] empty, full, eligible, wr_en, rd_en;
  logic [ChW-1:0]    rr_grant, grant;
  logic              rr_any, lock_elig, hold, wr_fire, rd_fire;

  // Channel index reached by stepping ofs places from base, wrapping at NUM_CH.
  function automatic int unsigned wrap_idx(input logic [ChW-1:0] base, input int unsigned ofs);
    int unsigned s;
    s = 32'(base) + ofs;
    return (s >= NUM_CH) ? s - NUM_CH : s;
  endfunction

  // Per-channel status derived from the pointers.
  always_comb begin
    empty         = '0;
    full          = '0;
    eligible      = '0;
    usage_o       = '0;
    almost_full_o = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      empty[c]         = (wptr_q[c] == rptr_q[c]);
      full[c]          = (wptr_q[c][LOG_DEPTH] != rptr_q[c][LOG_DEPTH]) &&
                         (wptr_q[c][LOG_DEPTH-1:0] == rptr_q[c][LOG_DEPTH-1:0]);
      usage_o[c]       = wptr_q[c] - rptr_q[c];
      almost_full_o[c] = (usage_o[c] >= CntW'(AF_THRESH));
      eligible[c]      = !empty[c] && !flush_i[c];
    end
  end

  // Write acceptance; an out-of-range channel is never ready.
  always_comb begin
    src_ready_o = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (src_ch_i == ChW'(c)) src_ready_o = !full[c] && !flush_i[c];
    end
  end

  // Grant: hold the locked channel while it stays eligible, else round-robin from rr_q.
  always_comb begin
    rr_any    = 1'b0;
    rr_grant  = rr_q;
    lock_elig = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!rr_any && eligible[c] && (c == wrap_idx(rr_q, i))) begin
          rr_any   = 1'b1;
          rr_grant = ChW'(c);
        end
      end
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (lock_ch_q == ChW'(c)) lock_elig = eligible[c];
    end
    hold        = (state_q == LOCKED) && lock_elig;
    grant       = hold ? lock_ch_q : rr_grant;
    dst_valid_o = hold || rr_any;
    dst_ch_o    = grant;
    dst_data_o  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant == ChW'(c)) dst_data_o = mem_q[c][rptr_q[c][LOG_DEPTH-1:0]];
    end
  end

  // Next pointers, arbiter pointer and lock FSM.
  always_comb begin
    wr_fire   = src_valid_i && src_ready_o;
    rd_fire   = dst_valid_o && dst_ready_i;
    wr_en     = '0;
    rd_en     = '0;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rr_d      = rr_q;
    state_d   = state_q;
    lock_ch_d = lock_ch_q;

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wr_en[c]  = wr_fire && (src_ch_i == ChW'(c));
      rd_en[c]  = rd_fire && (grant == ChW'(c));
      wptr_d[c] = wptr_q[c] + CntW'(wr_en[c]);
      rptr_d[c] = rptr_q[c] + CntW'(rd_en[c]);
      // Flush empties the channel and wins over any same-cycle traffic.
      if (flush_i[c]) begin
        wptr_d[c] = wptr_q[c];
        rptr_d[c] = wptr_q[c];
      end
    end

    if (rd_fire) begin
      rr_d = (grant == ChW'(NUM_CH - 1)) ? '0 : ChW'(grant + ChW'(1));
    end

    unique case (state_q)
      IDLE: begin
        if (dst_valid_o && !dst_ready_i) begin
          state_d   = LOCKED;
          lock_ch_d = grant;
        end
      end
      LOCKED: begin
        if (rd_fire) begin
          state_d = IDLE;
        end else if (!hold) begin
          // Locked channel flushed: release, or re-lock on the fallback grant if it stalls.
          if (dst_valid_o) lock_ch_d = grant;
          else             state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      rr_q      <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_q      <= rr_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  // Storage is not reset; the pointers alone define contents.
  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) mem_q[c][wptr_q[c][LOG_DEPTH-1:0]] <= src_data_i;
    end
  end

  ap_params: assert property (@(posedge clk_i)
    (LOG_DEPTH >= 1) && (NUM_CH >= 1) && (AF_THRESH >= 1) && (AF_THRESH <= Depth))
    else $error("multi_ch_fifo: illegal parameter set");

  ap_src_ch: assert property (@(posedge clk_i) disable iff (rst_i)
    src_valid_i |-> (32'(src_ch_i) < NUM_CH))
    else $error("multi_ch_fifo: src_ch_i out of range");

  ap_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (dst_valid_o && !dst_ready_i) |=> ((|flush_i) || ($stable(dst_ch_o) && $stable(dst_data_o))))
    else $error("multi_ch_fifo: output changed while stalled");

endmodule

// File: tb/tb_multi_ch_fifo.sv
// Scoreboard bench for multi_ch_fifo at default parameters (4 channels, depth 8,
// almost-full at 7). Stimulus pushes expected (channel, data) pairs; a negedge
// monitor pops and compares on every output handshake.
module tb_multi_ch_fifo;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CNTW = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NCH-1:0]            flush = '0;
  logic [7:0]                src_data = '0;
  logic [1:0]                src_ch = '0;
  logic                      src_valid = 1'b0;
  logic                      src_ready;
  logic [7:0]                dst_data;
  logic [1:0]                dst_ch;
  logic                      dst_valid;
  logic                      dst_ready = 1'b0;
  logic [NCH-1:0][CNTW-1:0]  usage;
  logic [NCH-1:0]            af;

  always #5 clk = ~clk;

  multi_ch_fifo dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .src_data_i    (src_data),
    .src_ch_i      (src_ch),
    .src_valid_i   (src_valid),
    .src_ready_o   (src_ready),
    .dst_data_o    (dst_data),
    .dst_ch_o      (dst_ch),
    .dst_valid_o   (dst_valid),
    .dst_ready_i   (dst_ready),
    .usage_o       (usage),
    .almost_full_o (af)
  );

  typedef struct {
    int ch;
    int data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input int ch, input int d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a write and check acceptance; the caller advances the clock.
  task automatic wr_set(input int ch, input int d, input logic exp_rdy, input bit push);
    src_ch    = 2'(ch);
    src_data  = 8'(d);
    src_valid = 1'b1;
    #1;
    chk("src_ready", 32'(src_ready), 32'(exp_rdy));
    if (push && exp_rdy) expect_out(ch, d);
  endtask

  task automatic wr(input int ch, input int d, input logic exp_rdy, input bit push);
    wr_set(ch, d, exp_rdy, push);
    tick();
    src_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(dst_valid), 0);
    chk("rst_usage", 32'(usage), 0);
    chk("rst_af", 32'(af), 0);
    chk("rst_src_ready", 32'(src_ready), 1);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(dst_valid), 0);
    chk("post_rst_usage", 32'(usage), 0);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    dst_ready = 1'b1;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    dst_ready = 1'b0;
    chk("drain_sb_empty", 32'(sb.size()), 0);
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && dst_valid && dst_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 1);
      end else begin
        mon_e = sb.pop_front();
        chk("out_ch", 32'(dst_ch), 32'(mon_e.ch));
        chk("out_data", 32'(dst_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    reset_dut();

    // Single write to ch2 appears the next cycle.
    wr(2, 'hA1, 1'b1, 1'b1);
    chk("t2_valid", 32'(dst_valid), 1);
    chk("t2_ch", 32'(dst_ch), 2);
    chk("t2_data", 32'(dst_data), 'hA1);
    chk("t2_usage2", 32'(usage[2]), 1);
    dst_ready = 1'b1;
    tick();
    dst_ready = 1'b0;
    chk("t2_usage2_after", 32'(usage[2]), 0);
    chk("t2_valid_after", 32'(dst_valid), 0);

    // Fill ch0 to full with the consumer stalled; almost-full from usage 7.
    for (int i = 0; i < 8; i++) begin
      wr(0, 'h10 + i, 1'b1, 1'b0);
      chk("t3_usage0", 32'(usage[0]), 32'(i + 1));
      chk("t3_af0", 32'(af[0]), 32'((i + 1) >= 7));
    end
    wr_set(0, 'hFF, 1'b0, 1'b0);
    wr(1, 'h77, 1'b1, 1'b0);
    chk("t3_usage0_full", 32'(usage[0]), 8);
    chk("t3_usage1", 32'(usage[1]), 1);
    chk("t3_af1", 32'(af[1]), 0);
    chk("t3_head_ch", 32'(dst_ch), 0);
    chk("t3_head_data", 32'(dst_data), 'h10);
    // rr_q is 3 here: ch0 (locked), ch1, then ch0 for the rest.
    expect_out(0, 'h10);
    expect_out(1, 'h77);
    for (int i = 1; i < 8; i++) expect_out(0, 'h10 + i);
    drain(30);
    chk("t3_usage_empty", 32'(usage), 0);

    // Reset mid-content discards everything; then round-robin from ch0.
    wr(2, 'hEE, 1'b1, 1'b0);
    reset_dut();
    tick();
    chk("t4_no_phantom", 32'(dst_valid), 0);
    for (int c = 0; c < 4; c++) wr(c, 'hA0 + c, 1'b1, 1'b1);
    dst_ready = 1'b1;
    repeat (4) tick();
    dst_ready = 1'b0;
    chk("t4_valid_done", 32'(dst_valid), 0);
    chk("t4_sb_empty", 32'(sb.size()), 0);

    // Stalled ch1 head holds while ch0 fills; flush of ch1 moves output to ch0.
    wr(1, 'h55, 1'b1, 1'b0);
    chk("t5_ch", 32'(dst_ch), 1);
    chk("t5_data", 32'(dst_data), 'h55);
    for (int k = 0; k < 3; k++) begin
      wr(0, 'h30 + k, 1'b1, 1'b1);
      chk("t5_hold_valid", 32'(dst_valid), 1);
      chk("t5_hold_ch", 32'(dst_ch), 1);
      chk("t5_hold_data", 32'(dst_data), 'h55);
    end
    flush = 4'b0010;
    wr_set(1, 'h99, 1'b0, 1'b0);
    chk("t5_flush_valid", 32'(dst_valid), 1);
    chk("t5_flush_ch", 32'(dst_ch), 0);
    tick();
    flush = '0;
    src_valid = 1'b0;
    chk("t5_usage1", 32'(usage[1]), 0);
    chk("t5_usage0", 32'(usage[0]), 3);
    chk("t5_after_valid", 32'(dst_valid), 1);
    chk("t5_after_ch", 32'(dst_ch), 0);
    chk("t5_after_data", 32'(dst_data), 'h30);
    drain(10);

    // Full ch3: a concurrent read and write must reject the write.
    reset_dut();
    for (int k = 0; k < 8; k++) wr(3, 'hC0 + k, 1'b1, 1'b1);
    chk("t6_usage3", 32'(usage[3]), 8);
    chk("t6_af3", 32'(af[3]), 1);
    dst_ready = 1'b1;
    wr_set(3, 'hEE, 1'b0, 1'b0);
    chk("t6_valid", 32'(dst_valid), 1);
    chk("t6_ch", 32'(dst_ch), 3);
    tick();
    src_valid = 1'b0;
    dst_ready = 1'b0;
    chk("t6_usage3_after", 32'(usage[3]), 7);
    drain(20);

    // 20 back-to-back writes/reads on ch0 wrap the pointers; order preserved.
    dst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_set(0, (i * 13 + 5) & 'hFF, 1'b1, 1'b1);
      if (i > 0) chk("t7_usage_steady", 32'(usage[0]), 1);
      tick();
    end
    src_valid = 1'b0;
    tick();
    dst_ready = 1'b0;
    chk("t7_usage_zero", 32'(usage[0]), 0);
    chk("t7_sb_empty", 32'(sb.size()), 0);
    chk("t7_valid_done", 32'(dst_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_ch_fifo.md
MULTI_CH_FIFO -- requirements
Module: multi_ch_fifo

Interface
REQ-001: Parameter WIDTH, default 8: payload width in bits.
REQ-002: Parameter T, default logic [WIDTH-1:0]: payload type.
REQ-003: Parameter NUM_CH, default 4: number of independent channel FIFOs, >= 1.
REQ-004: Parameter LOG_DEPTH, default 3: per-channel depth is 2**LOG_DEPTH, >= 1.
REQ-005: Parameter AF_THRESH, default 2**LOG_DEPTH-1: almost-full level, range 1..2**LOG_DEPTH.
REQ-006: Derived ChW = max(1, $clog2(NUM_CH)); CntW = LOG_DEPTH+1.
REQ-007: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-008: rst_i  in  1  reset, asynchronous, active-high.
REQ-009: flush_i  in  NUM_CH  per-channel synchronous clear.
REQ-010: src_data_i  in  T  write payload.
REQ-011: src_ch_i  in  ChW  target channel of write.
REQ-012: src_valid_i  in  1  write request.
REQ-013: src_ready_o  out  1  write accepted when high with src_valid_i.
REQ-014: dst_data_o  out  T  head payload of granted channel.
REQ-015: dst_ch_o  out  ChW  granted channel index.
REQ-016: dst_valid_o  out  1  output holds a valid entry.
REQ-017: dst_ready_i  in  1  consumer accepts.
REQ-018: usage_o  out  NUM_CH x CntW  per-channel fill level, 0..2**LOG_DEPTH.
REQ-019: almost_full_o  out  NUM_CH  per-channel usage >= AF_THRESH.

Function
REQ-020: Each channel SHALL hold a circular buffer with CntW-bit read/write pointers; low LOG_DEPTH bits address storage, MSB disambiguates full (MSBs differ, rest equal) from empty (pointers equal); pointers wrap modulo 2**CntW.
REQ-021: src_ready_o SHALL equal NOT full[src_ch_i] AND NOT flush_i[src_ch_i]; it SHALL NOT depend on dst_ready_i (no full-and-read bypass).
REQ-022: Write handshake (src_valid_i & src_ready_o) SHALL store src_data_i at that channel's write pointer and increment it at the clock edge.
REQ-023: Write-to-read latency SHALL be 1 cycle: entry written at edge k is eligible for dst_valid_o in cycle k+1.
REQ-024: Eligible channel = non-empty AND flush_i bit low.
REQ-025: Arbiter SHALL be round-robin: register rr_q (ChW bits, reset 0); grant = first eligible channel searching rr_q, rr_q+1, ... wrapping at NUM_CH.
REQ-026: On read handshake (dst_valid_o & dst_ready_i) the granted channel's read pointer SHALL increment and rr_q SHALL become (granted+1) mod NUM_CH.
REQ-027: dst_valid_o SHALL be high iff any channel is eligible; dst_data_o = head of granted channel; dst_ch_o = granted index.
REQ-028: Two-state lock FSM: IDLE -> LOCKED when dst_valid_o & !dst_ready_i; LOCKED -> IDLE on read handshake or flush of locked channel; in LOCKED grant SHALL stay on the locked channel so dst_data_o/dst_ch_o stay stable.
REQ-029: Flush of the locked channel SHALL be the only case dst_valid_o may drop without handshake.
REQ-030: Simultaneous write and read on one channel SHALL leave usage unchanged; both pointers advance.
REQ-031: flush_i[c] SHALL set channel c read and write pointers equal (empty) at the next edge, overriding any write or read to c that cycle; other channels unaffected.
REQ-032: usage_o[c] = wptr - rptr modulo 2**CntW, combinational from pointers; almost_full_o[c] = usage_o[c] >= AF_THRESH.
REQ-033: NUM_CH=1 SHALL degenerate to a single FIFO, dst_ch_o constant 0.
REQ-034: Simulation assertions: LOG_DEPTH>=1, NUM_CH>=1, AF_THRESH in range, src_ch_i < NUM_CH when src_valid_i, dst_data_o/dst_ch_o stable while dst_valid_o & !dst_ready_i absent flush.

Reset
REQ-035: rst_i high SHALL asynchronously clear all pointers, rr_q, and lock FSM to IDLE; storage not reset.
REQ-036: During/after reset: dst_valid_o=0, usage_o=0, almost_full_o=0, src_ready_o=1 (absent flush).
REQ-037: Reset mid-transfer SHALL discard all contents; no output handshake in the cycle reset deasserts.

Verification
REQ-038: Reset, write 0xA1 to ch2 -> next cycle dst_valid_o=1, dst_ch_o=2, dst_data_o=0xA1, usage_o[2]=1.
REQ-039: LOG_DEPTH=3, 8 writes to ch0 with dst_ready_i=0 -> src_ready_o=0 for ch0, usage_o[0]=8, almost_full_o[0]=1 from usage 7; 9th write to ch1 accepted.
REQ-040: One entry each in ch0..ch3, dst_ready_i=1 -> output order ch0,ch1,ch2,ch3 over 4 cycles, then dst_valid_o=0.
REQ-041: ch1 head 0x55 presented, dst_ready_i=0 for 3 cycles while ch0 written -> dst_ch_o=1, dst_data_o=0x55 held; flush_i[1] -> dst_valid_o switches to ch0 next cycle.
REQ-042: ch3 full, simultaneous read ch3 and write ch3 attempt -> write rejected (src_ready_o=0), usage_o[3]=7 after edge.
REQ-043: 20 writes/reads on ch0 with full wrap -> data order preserved, usage returns to 0.
